// File: rtl/tb_transaction_sequencer.sv
// Sequences a DUT through NUM_TRANSACTIONS start/end handshakes, pulsing done between them.
// Moore outputs (1-cycle reaction to start_ready/end_valid); stalls indefinitely on either channel unless the timeout fires.
module tb_transaction_sequencer #(
  parameter int NUM_TRANSACTIONS = 1,
  parameter int DONE_CYCLES      = 2,
  parameter int TIMEOUT_CYCLES   = 100000,
  parameter int COUNT_WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   start_valid,
  input  logic                   start_ready,
  input  logic                   end_valid,
  output logic                   end_ready,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] trans_count,
  output logic                   finished,
  output logic                   timeout
);

  typedef enum logic [2:0] {
    IDLE,
    DONE_HI,
    DONE_LO,
    START,
    RUN,
    FINISH,
    TIMEOUT
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] ONE         = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [COUNT_WIDTH-1:0] NUM_TRANS_W = COUNT_WIDTH'(NUM_TRANSACTIONS);
  localparam logic [COUNT_WIDTH-1:0] DONE_LAST   = COUNT_WIDTH'(DONE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] TIMER_LAST  = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam bit                     TIMER_EN    = (TIMEOUT_CYCLES != 0);

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   done_cnt_q;
  logic [COUNT_WIDTH-1:0]   timer_q;
  logic [COUNT_WIDTH-1:0]   trans_count_q;
  logic                     timer_expired;
  logic                     start_hs;
  logic                     end_hs;

  assign timer_expired = TIMER_EN && (timer_q == TIMER_LAST);
  assign start_hs      = (state_q == START) && start_ready;
  assign end_hs        = (state_q == RUN) && end_valid;

  // A completing handshake always takes priority over timer expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = DONE_HI;
      DONE_HI: if (done_cnt_q == DONE_LAST) state_d = DONE_LO;
      DONE_LO: state_d = (trans_count_q == NUM_TRANS_W) ? FINISH : START;
      START: begin
        if (start_hs)           state_d = RUN;
        else if (timer_expired) state_d = TIMEOUT;
      end
      RUN: begin
        if (end_hs)             state_d = DONE_HI;
        else if (timer_expired) state_d = TIMEOUT;
      end
      FINISH:  state_d = FINISH;
      TIMEOUT: state_d = TIMEOUT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_q <= '0;
    end else if (state_q == DONE_HI) begin
      done_cnt_q <= done_cnt_q + ONE;
    end else begin
      done_cnt_q <= '0;
    end
  end

  // Timer restarts on each START entry and keeps running through RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if ((state_d == START) && (state_q != START)) begin
      timer_q <= '0;
    end else if (((state_q == START) || (state_q == RUN)) && (timer_q != CNT_MAX)) begin
      timer_q <= timer_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trans_count_q <= '0;
    end else if (end_hs && (trans_count_q != CNT_MAX)) begin
      trans_count_q <= trans_count_q + ONE;
    end
  end

  assign done        = (state_q == DONE_HI);
  assign start_valid = (state_q == START);
  assign end_ready   = (state_q == RUN);
  assign finished    = (state_q == FINISH) || (state_q == TIMEOUT);
  assign timeout     = (state_q == TIMEOUT);
  assign trans_count = trans_count_q;

endmodule
